int16_requant_stream: RTL and testbench

INT16_REQUANT_STREAM -- requirements
Module: int16_requant_stream

---
 rtl/int16_requant_stream.sv | 111 +++++++++++
 tb/tb_int16_requant_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/int16_requant_stream.sv
// Requantizes rows of LANES signed int16 to int8 with round-half-up shift and saturation; 1-cycle latency,
// single output register stalls input while full and unread. Define REQUANT_RELU_EN to clamp negatives to 0.
module int16_requant_stream #(
  parameter int ROWS  = 128,
  parameter int LANES = 128
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_ce,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic                  ap_continue,
  input  logic [3:0]            shift,
  input  logic [LANES*16-1:0]   c_tdata,
  input  logic                  c_tvalid,
  output logic                  c_tready,
  output logic [LANES*8-1:0]    q_tdata,
  output logic                  q_tvalid,
  input  logic                  q_tready
);

  localparam int CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [CW-1:0] LAST_C = CW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        in_cnt_q;
  logic [CW-1:0]        out_cnt_q;
  logic [3:0]           shift_q;
  logic [LANES*8-1:0]   q_tdata_q;
  logic [LANES*8-1:0]   q_tdata_d;
  logic                 q_tvalid_q;
  logic                 in_xfer;
  logic                 out_xfer;

  // 17 bits hold x + r without overflow: 32767 + 16384 < 2^16.
  function automatic logic [7:0] requant(input logic [15:0] x, input logic [3:0] sh);
    logic signed [16:0] r;
    logic signed [16:0] y;
    r = (sh == 4'd0) ? 17'sd0 : (17'sd1 <<< (sh - 4'd1));
    y = ($signed({x[15], x}) + r) >>> sh;
`ifdef REQUANT_RELU_EN
    if (y < 17'sd0) y = 17'sd0;
`endif
    if (y > 17'sd127)       return 8'h7f;
    else if (y < -17'sd128) return 8'h80;
    else                    return y[7:0];
  endfunction

  always_comb begin
    q_tdata_d = '0;
    for (int i = 0; i < LANES; i++) begin
      q_tdata_d[i*8 +: 8] = requant(c_tdata[i*16 +: 16], shift_q);
    end
  end

  assign c_tready = ap_ce && (state_q == S_RUN) && (in_cnt_q < ROWS_C) && (!q_tvalid_q || q_tready);
  assign in_xfer  = c_tvalid && c_tready;
  assign out_xfer = q_tvalid_q && q_tready && ap_ce;

  assign ap_idle  = (state_q == S_IDLE);
  assign ap_ready = (state_q == S_IDLE);
  assign ap_done  = (state_q == S_DONE);
  assign q_tdata  = q_tdata_q;
  assign q_tvalid = q_tvalid_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      shift_q    <= '0;
      q_tdata_q  <= '0;
      q_tvalid_q <= 1'b0;
    end else if (ap_ce) begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            state_q   <= S_RUN;
            shift_q   <= shift;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end
        end
        S_RUN: begin
          // A reload in the same cycle as a drain keeps the register full.
          if (in_xfer) begin
            q_tdata_q  <= q_tdata_d;
            q_tvalid_q <= 1'b1;
            in_cnt_q   <= in_cnt_q + 1'b1;
          end else if (out_xfer) begin
            q_tvalid_q <= 1'b0;
          end
          if (out_xfer) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            if (out_cnt_q == LAST_C) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ap_continue) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int16_requant_stream.sv
// Directed bench for int16_requant_stream: full jobs with stalls, clock-enable gaps, mid-job reset.
module tb_int16_requant_stream;

  localparam int ROWS  = 128;
  localparam int LANES = 128;

  logic                ap_clk;
  logic                ap_rst;
  logic                ap_ce;
  logic                ap_start;
  logic                ap_idle;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_continue;
  logic [3:0]          shift;
  logic [LANES*16-1:0] c_tdata;
  logic                c_tvalid;
  logic                c_tready;
  logic [LANES*8-1:0]  q_tdata;
  logic                q_tvalid;
  logic                q_tready;

  int checks = 0;
  int errors = 0;

  logic [15:0]        dir_v [5];
  int                 n_dir;
  logic [LANES*8-1:0] first_q;

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s got %0h exp %0h", tag, obs, exp); \
    end \
  end

  int16_requant_stream #(.ROWS(ROWS), .LANES(LANES)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .shift(shift), .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .q_tdata(q_tdata), .q_tvalid(q_tvalid), .q_tready(q_tready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [15:0] gen_lane(input int seed, input int r, input int i);
    int v;
    if (r == 0 && i < n_dir) return dir_v[i];
    if ((r + i) % 37 == 0) return 16'h8000;
    v = r * 1237 + i * 4099 + seed * 7919;
    if (i % 3 == 0) v = v % 700 - 350;
    return v[15:0];
  endfunction

  // Integer reference: floor((x + half) / 2^s), optional ReLU, clamp to int8.
  function automatic logic [7:0] ref_q(input logic [15:0] x, input int s);
    int v;
    v = int'($signed(x));
    if (s > 0) v = v + (1 << (s - 1));
    v = v >>> s;
`ifdef REQUANT_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [LANES*16-1:0] mk_in(input int seed, input int r);
    logic [LANES*16-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*16 +: 16] = gen_lane(seed, r, i);
    return d;
  endfunction

  function automatic logic [LANES*8-1:0] mk_out(input int seed, input int r, input int s);
    logic [LANES*8-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*8 +: 8] = ref_q(gen_lane(seed, r, i), s);
    return d;
  endfunction

  task automatic run_job(input int s, input int s_late, input int abort_at,
                         input int rdy_mode, input int ce_mode, input int seed);
    int in_idx;
    int out_idx;
    int cyc;
    int bad_lane;
    logic hold_v;
    logic ok_in;
    logic ok_out;
    logic [LANES*8-1:0] hold_d;
    logic [LANES*8-1:0] exp_row;
    in_idx = 0; out_idx = 0; cyc = 0; hold_v = 1'b0; hold_d = '0;
    ap_ce = 1'b1; ap_start = 1'b1; shift = 4'(s);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    `CHK("run_entered", ap_idle, 1'b0)
    while (out_idx < ROWS && cyc < 4000) begin
      if (hold_v) `CHK("stall_stable", (q_tvalid === 1'b1 && q_tdata === hold_d), 1'b1)
      if (cyc == 10) shift = 4'(s_late);
      ap_ce    = (ce_mode != 0 && cyc % 7 == 3) ? 1'b0 : 1'b1;
      q_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      c_tvalid = (in_idx < ROWS) && (cyc % 5 != 4);
      c_tdata  = mk_in(seed, in_idx);
      ap_start = (cyc % 11 == 5);
      #1;
      ok_in  = c_tvalid && c_tready;
      ok_out = q_tvalid && q_tready && ap_ce;
      if (ok_out) begin
        exp_row = mk_out(seed, out_idx, s);
        checks++;
        assert (q_tdata === exp_row) else begin
          errors++;
          bad_lane = 0;
          for (int i = LANES - 1; i >= 0; i--) if (q_tdata[i*8 +: 8] !== exp_row[i*8 +: 8]) bad_lane = i;
          $error("FAIL row%0d lane%0d got %0h exp %0h", out_idx, bad_lane,
                 q_tdata[bad_lane*8 +: 8], exp_row[bad_lane*8 +: 8]);
        end
        if (out_idx == 0) first_q = q_tdata;
        out_idx++;
      end
      if (ok_in) in_idx++;
      hold_v = q_tvalid && !ok_out;
      hold_d = q_tdata;
      @(posedge ap_clk); #1;
      cyc++;
      if (abort_at > 0 && out_idx == abort_at) begin
        ap_rst = 1'b1;
        #1;
        `CHK("rst_q_tvalid", q_tvalid, 1'b0)
        `CHK("rst_ap_idle", ap_idle, 1'b1)
        `CHK("rst_ap_done", ap_done, 1'b0)
        `CHK("rst_c_tready", c_tready, 1'b0)
        `CHK("rst_q_tdata_zero", (q_tdata == '0), 1'b1)
        c_tvalid = 1'b0; ap_start = 1'b0; ap_ce = 1'b1; q_tready = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        `CHK("no_resume_idle", ap_idle, 1'b1)
        `CHK("no_resume_q_tvalid", q_tvalid, 1'b0)
        return;
      end
    end
    c_tvalid = 1'b0; ap_start = 1'b0; ap_ce = 1'b1;
    `CHK("job_rows_out", out_idx, ROWS)
    `CHK("job_rows_in", in_idx, ROWS)
    `CHK("done_after_last", ap_done, 1'b1)
    `CHK("done_c_tready_low", c_tready, 1'b0)
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    `CHK("start_ignored_in_done", ap_done, 1'b1)
    ap_ce = 1'b0; ap_continue = 1'b1;
    @(posedge ap_clk); #1;
    `CHK("ce_low_holds_done", ap_done, 1'b1)
    ap_ce = 1'b1;
    @(posedge ap_clk); #1;
    ap_continue = 1'b0;
    `CHK("idle_after_continue", ap_idle, 1'b1)
    `CHK("ready_after_continue", ap_ready, 1'b1)
    `CHK("done_cleared", ap_done, 1'b0)
  endtask

  initial begin
    ap_rst = 1'b1; ap_ce = 1'b1; ap_start = 1'b0; ap_continue = 1'b0; shift = 4'd0;
    c_tdata = '0; c_tvalid = 1'b0; q_tready = 1'b0; n_dir = 0; first_q = '0;
    for (int i = 0; i < 5; i++) dir_v[i] = 16'h0000;
    #12;
    `CHK("reset_idle", ap_idle, 1'b1)
    `CHK("reset_ready", ap_ready, 1'b1)
    `CHK("reset_done", ap_done, 1'b0)
    `CHK("reset_c_tready", c_tready, 1'b0)
    `CHK("reset_q_tvalid", q_tvalid, 1'b0)
    `CHK("reset_q_tdata_zero", (q_tdata == '0), 1'b1)
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    `CHK("idle_after_reset", ap_idle, 1'b1)

    // Job A: shift 0, q_tready toggling every other cycle.
`ifdef REQUANT_RELU_EN
    n_dir = 3; dir_v[0] = 16'hfffb; dir_v[1] = 16'h0005; dir_v[2] = 16'h8000;
`else
    n_dir = 4; dir_v[0] = 16'd100; dir_v[1] = 16'hff9c; dir_v[2] = 16'd300; dir_v[3] = 16'hfed4;
`endif
    run_job(0, 0, 0, 1, 0, 1);
`ifdef REQUANT_RELU_EN
    `CHK("relu_neg5", first_q[7:0], 8'h00)
    `CHK("relu_pos5", first_q[15:8], 8'h05)
    `CHK("relu_min", first_q[23:16], 8'h00)
`else
    `CHK("s0_100", first_q[7:0], 8'h64)
    `CHK("s0_m100", first_q[15:8], 8'h9c)
    `CHK("s0_300_sat", first_q[23:16], 8'h7f)
    `CHK("s0_m300_sat", first_q[31:24], 8'h80)
`endif

    // Job B: shift 4 rounding, clock-enable gaps.
    n_dir = 5; dir_v[0] = 16'd24; dir_v[1] = 16'd23; dir_v[2] = 16'hffe8;
    dir_v[3] = 16'hffe7; dir_v[4] = 16'd2047;
    run_job(4, 4, 0, 0, 1, 2);
    `CHK("s4_24", first_q[7:0], 8'h02)
    `CHK("s4_23", first_q[15:8], 8'h01)
`ifdef REQUANT_RELU_EN
    `CHK("s4_m24_relu", first_q[23:16], 8'h00)
    `CHK("s4_m25_relu", first_q[31:24], 8'h00)
`else
    `CHK("s4_m24", first_q[23:16], 8'hff)
    `CHK("s4_m25", first_q[31:24], 8'hfe)
`endif
    `CHK("s4_2047_sat", first_q[39:32], 8'h7f)

    // Job C: shift changes 2 -> 7 mid-job, random backpressure; rows must all use shift 2.
    n_dir = 0;
    run_job(2, 7, 0, 2, 0, 3);

    // Job D: reset after 40 rows, then a fresh full job.
    run_job(5, 5, 40, 1, 0, 4);
    run_job(3, 3, 0, 1, 1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
